// File: rtl/sdc_pkg.sv
// rtl/sdc_pkg.sv - shared types and constants for the sdc_alu front end
package sdc_pkg;

  typedef enum logic [4:0] {
    FCN_NOT = 5'd0,
    FCN_OR  = 5'd1,
    FCN_AND = 5'd2,
    FCN_XOR = 5'd3,
    FCN_ADD = 5'd4,
    FCN_SUB = 5'd5
  } alu_fcn_e;

  localparam logic [4:0] FCN_LAST_LEGAL = 5'd5;

  localparam int FLG_CR   = 0;
  localparam int FLG_ZERO = 1;
  localparam int FLG_NEG  = 2;
  localparam int FLG_ERR  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic fcn_is_legal(input logic [4:0] fcn);
    return fcn <= FCN_LAST_LEGAL;
  endfunction

endpackage

// File: rtl/sdc_alu_arb_if.sv
// rtl/sdc_alu_arb_if.sv - request, response and ALU-side signals of sdc_alu_arb
interface sdc_alu_arb_if #(
  parameter int BIT_WIDTH = 32,
  parameter int ERR_CNT_W = 8
);
  logic                 req0_valid;
  logic                 req0_ready;
  logic [4:0]           req0_fcn;
  logic [BIT_WIDTH-1:0] req0_a;
  logic [BIT_WIDTH-1:0] req0_b;

  logic                 req1_valid;
  logic                 req1_ready;
  logic [4:0]           req1_fcn;
  logic [BIT_WIDTH-1:0] req1_a;
  logic [BIT_WIDTH-1:0] req1_b;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_id;
  logic [BIT_WIDTH-1:0] rsp_data;
  logic [3:0]           rsp_flags;

  logic [BIT_WIDTH-1:0] alu_in1;
  logic [BIT_WIDTH-1:0] alu_in2;
  logic [4:0]           alu_fcn;
  logic [BIT_WIDTH-1:0] alu_out;
  logic                 alu_cr;

  logic [ERR_CNT_W-1:0] err_cnt;

  // The arbiter block itself.
  modport slave (
    input  req0_valid, req0_fcn, req0_a, req0_b,
    input  req1_valid, req1_fcn, req1_a, req1_b,
    input  rsp_ready, alu_out, alu_cr,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_flags,
    output alu_in1, alu_in2, alu_fcn, err_cnt
  );

  // Requesters, response consumer and the attached ALU.
  modport master (
    output req0_valid, req0_fcn, req0_a, req0_b,
    output req1_valid, req1_fcn, req1_a, req1_b,
    output rsp_ready, alu_out, alu_cr,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_flags,
    input  alu_in1, alu_in2, alu_fcn, err_cnt
  );
endinterface

// File: rtl/sdc_rr_arb2.sv
// rtl/sdc_rr_arb2.sv - two-way round-robin arbiter with priority pointer
module sdc_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);
  logic ptr_q;
  logic ptr_d;

  // Lone requester always wins; on contention the pointer picks the port.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = ptr_q ? 2'b10 : 2'b01;
    end
  end

  // After a grant the other port becomes favoured.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && (grant != 2'b00)) begin
      ptr_d = ~grant[1];
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: rtl/sdc_alu_arb.sv
// rtl/sdc_alu_arb.sv - round-robin front end and result capture for the shared ALU
module sdc_alu_arb
  import sdc_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int ERR_CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  sdc_alu_arb_if.slave  bus
);
  state_e               state_q, state_d;
  logic                 id_q, id_d;
  logic [BIT_WIDTH-1:0] alu_in1_q, alu_in1_d;
  logic [BIT_WIDTH-1:0] alu_in2_q, alu_in2_d;
  logic [4:0]           alu_fcn_q, alu_fcn_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_id_q, rsp_id_d;
  logic [BIT_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [3:0]           rsp_flags_q, rsp_flags_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [1:0]           grant;
  logic                 accept;
  logic                 fcn_legal;
  logic [3:0]           cap_flags;

  assign accept = (state_q == IDLE) && (grant != 2'b00);

  sdc_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   ({bus.req1_valid, bus.req0_valid}),
    .advance (accept),
    .grant   (grant)
  );

  assign bus.req0_ready = (state_q == IDLE) && grant[0];
  assign bus.req1_ready = (state_q == IDLE) && grant[1];

  assign bus.alu_in1   = alu_in1_q;
  assign bus.alu_in2   = alu_in2_q;
  assign bus.alu_fcn   = alu_fcn_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign bus.err_cnt   = err_cnt_q;

  // Status flags derived from the ALU result; zero is computed locally.
  always_comb begin
    fcn_legal = fcn_is_legal(alu_fcn_q);
    cap_flags = 4'b0000;
    if (fcn_legal) begin
      cap_flags[FLG_ZERO] = (bus.alu_out == '0);
      cap_flags[FLG_NEG]  = bus.alu_out[BIT_WIDTH-1];
      cap_flags[FLG_CR]   = bus.alu_cr &&
                            ((alu_fcn_q == FCN_ADD) || (alu_fcn_q == FCN_SUB));
    end else begin
      cap_flags[FLG_ERR]  = 1'b1;
    end
  end

  // Next-state logic: accept in IDLE, capture in EXEC, handshake in RESP.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    alu_in1_d   = alu_in1_q;
    alu_in2_d   = alu_in2_q;
    alu_fcn_d   = alu_fcn_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = EXEC;
          id_d      = grant[1];
          alu_fcn_d = grant[1] ? bus.req1_fcn : bus.req0_fcn;
          alu_in1_d = grant[1] ? bus.req1_a   : bus.req0_a;
          alu_in2_d = grant[1] ? bus.req1_b   : bus.req0_b;
        end
      end
      EXEC: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_data_d  = fcn_legal ? bus.alu_out : '0;
        rsp_flags_d = cap_flags;
        if (!fcn_legal && (err_cnt_q != '1)) begin
          err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // FSM, operand and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      id_q        <= 1'b0;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      alu_fcn_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      alu_in1_q   <= alu_in1_d;
      alu_in2_q   <= alu_in2_d;
      alu_fcn_q   <= alu_fcn_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      err_cnt_q   <= err_cnt_d;
    end
  end
endmodule

// File: tb/tb_sdc_alu_arb.sv
// tb/tb_sdc_alu_arb.sv - self-checking bench for sdc_alu_arb
module tb_sdc_alu_arb;
  localparam int BW = 32;
  localparam int EW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdc_alu_arb_if #(.BIT_WIDTH(BW), .ERR_CNT_W(EW)) bus ();

  sdc_alu_arb #(.BIT_WIDTH(BW), .ERR_CNT_W(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  logic          drv_v0, drv_v1, drv_rdy;
  logic [4:0]    p_fcn [2];
  logic [31:0]   p_a   [2];
  logic [31:0]   p_b   [2];
  int            fav;
  int            err_model;
  logic [31:0]   o_data;
  logic [3:0]    o_flags;
  logic          o_id;
  int            grant_log [$];

  assign bus.req0_valid = drv_v0;
  assign bus.req1_valid = drv_v1;
  assign bus.req0_fcn   = p_fcn[0];
  assign bus.req0_a     = p_a[0];
  assign bus.req0_b     = p_b[0];
  assign bus.req1_fcn   = p_fcn[1];
  assign bus.req1_a     = p_a[1];
  assign bus.req1_b     = p_b[1];
  assign bus.rsp_ready  = drv_rdy;

  // Attached ALU; logic ops and illegal codes drive junk carry/data.
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum     = 33'd0;
    bus.alu_out = 32'd0;
    bus.alu_cr  = 1'b1;
    case (bus.alu_fcn)
      5'd0: bus.alu_out = ~bus.alu_in1;
      5'd1: bus.alu_out = bus.alu_in1 | bus.alu_in2;
      5'd2: bus.alu_out = bus.alu_in1 & bus.alu_in2;
      5'd3: bus.alu_out = bus.alu_in1 ^ bus.alu_in2;
      5'd4: begin
        alu_sum     = {1'b0, bus.alu_in1} + {1'b0, bus.alu_in2};
        bus.alu_out = alu_sum[31:0];
        bus.alu_cr  = alu_sum[32];
      end
      5'd5: begin
        alu_sum     = {1'b0, bus.alu_in1} + {1'b0, ~bus.alu_in2} + 33'd1;
        bus.alu_out = alu_sum[31:0];
        bus.alu_cr  = alu_sum[32];
      end
      default: bus.alu_out = bus.alu_in1 ^ bus.alu_in2 ^ 32'hA5A5_5A5A;
    endcase
  end

  function automatic logic [31:0] ref_data(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      5'd0:    return ~a;
      5'd1:    return a | b;
      5'd2:    return a & b;
      5'd3:    return a ^ b;
      5'd4:    return a + b;
      5'd5:    return a - b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] ref_flags(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    logic        cr;
    if (f > 5'd5) return 4'b1000;
    d  = ref_data(f, a, b);
    cr = 1'b0;
    if (f == 5'd4) cr = ((64'(a) + 64'(b)) > 64'h0000_0000_FFFF_FFFF);
    if (f == 5'd5) cr = (a >= b);
    return {1'b0, d[31], (d == 32'd0), cr};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_id"},    32'(bus.rsp_id),    32'd0);
    chk({tag, "_rsp_data"},  bus.rsp_data,       32'd0);
    chk({tag, "_rsp_flags"}, 32'(bus.rsp_flags), 32'd0);
    chk({tag, "_alu_in1"},   bus.alu_in1,        32'd0);
    chk({tag, "_alu_in2"},   bus.alu_in2,        32'd0);
    chk({tag, "_alu_fcn"},   32'(bus.alu_fcn),   32'd0);
    chk({tag, "_err_cnt"},   32'(bus.err_cnt),   32'd0);
  endtask

  task automatic do_reset(input string tag);
    drv_v0  = 1'b0;
    drv_v1  = 1'b0;
    drv_rdy = 1'b0;
    rst     = 1'b1;
    #1;
    chk_reset_outputs(tag);
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    fav       = 0;
    err_model = 0;
  endtask

  task automatic rnd_req(input int p, input bit ill);
    p_fcn[p] = ill ? 5'($urandom_range(0, 9)) : 5'($urandom_range(0, 5));
    p_a[p]   = $urandom;
    p_b[p]   = ($urandom_range(0, 3) == 0) ? p_a[p] : $urandom;
  endtask

  // One transaction starting in IDLE; ends in IDLE after the handshake.
  task automatic one_txn(input bit v0, input bit v1, input int stall,
                         input bit renew, input bit ill, input string tag);
    int          w;
    logic [4:0]  f;
    logic [31:0] a, b, ed;
    logic [3:0]  ef;
    drv_v0 = v0;
    drv_v1 = v1;
    #1;
    w = (v0 && v1) ? fav : (v1 ? 1 : 0);
    chk({tag, "_ready0"}, 32'(bus.req0_ready), 32'(w == 0));
    chk({tag, "_ready1"}, 32'(bus.req1_ready), 32'(w == 1));
    f  = p_fcn[w];
    a  = p_a[w];
    b  = p_b[w];
    ed = ref_data(f, a, b);
    ef = ref_flags(f, a, b);
    grant_log.push_back(w);
    @(posedge clk);
    #1;
    fav = 1 - w;
    if (f > 5'd5 && err_model < 255) err_model++;
    if (renew) rnd_req(w, ill);
    else if (w == 0) drv_v0 = 1'b0;
    else drv_v1 = 1'b0;
    drv_rdy = 1'($urandom_range(0, 1));
    #1;
    chk({tag, "_exec_valid"},  32'(bus.rsp_valid), 32'd0);
    chk({tag, "_exec_ready"},  32'(bus.req0_ready | bus.req1_ready), 32'd0);
    chk({tag, "_exec_fcn"},    32'(bus.alu_fcn), 32'(f));
    chk({tag, "_exec_in1"},    bus.alu_in1, a);
    chk({tag, "_exec_in2"},    bus.alu_in2, b);
    @(posedge clk);
    #1;
    drv_rdy = 1'b0;
    #1;
    chk({tag, "_rsp_valid"},   32'(bus.rsp_valid), 32'd1);
    chk({tag, "_rsp_id"},      32'(bus.rsp_id), 32'(w));
    chk({tag, "_rsp_data"},    bus.rsp_data, ed);
    chk({tag, "_rsp_flags"},   32'(bus.rsp_flags), 32'(ef));
    chk({tag, "_err_cnt"},     32'(bus.err_cnt), 32'(err_model));
    o_data  = bus.rsp_data;
    o_flags = bus.rsp_flags;
    o_id    = bus.rsp_id;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, "_hold_data"},  bus.rsp_data, ed);
      chk({tag, "_hold_flags"}, 32'(bus.rsp_flags), 32'(ef));
      chk({tag, "_hold_id"},    32'(bus.rsp_id), 32'(w));
      chk({tag, "_hold_ready"}, 32'(bus.req0_ready | bus.req1_ready), 32'd0);
    end
    drv_rdy = 1'b1;
    @(posedge clk);
    #1;
    drv_rdy = 1'b0;
    #1;
    chk({tag, "_done_valid"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int p = 0; p < 2; p++) begin
      p_fcn[p] = 5'd0;
      p_a[p]   = 32'd0;
      p_b[p]   = 32'd0;
    end
    do_reset("rst0");

    // ADD with carry out and zero result.
    p_fcn[0] = 5'd4; p_a[0] = 32'hFFFF_FFFF; p_b[0] = 32'd1;
    one_txn(1'b1, 1'b0, 0, 1'b0, 1'b0, "tp1");
    chk("tp1_id",    32'(o_id), 32'd0);
    chk("tp1_data",  o_data, 32'd0);
    chk("tp1_flags", 32'(o_flags), 32'h3);

    // Contention from reset: port 0 first, then port 1.
    do_reset("rst1");
    p_fcn[0] = 5'd5; p_a[0] = 32'd5; p_b[0] = 32'd7;
    p_fcn[1] = 5'd1; p_a[1] = 32'd3; p_b[1] = 32'd4;
    one_txn(1'b1, 1'b1, 0, 1'b0, 1'b0, "tp2a");
    chk("tp2a_id",    32'(o_id), 32'd0);
    chk("tp2a_data",  o_data, 32'hFFFF_FFFE);
    chk("tp2a_flags", 32'(o_flags), 32'h4);
    one_txn(1'b0, 1'b1, 0, 1'b0, 1'b0, "tp2b");
    chk("tp2b_id",    32'(o_id), 32'd1);
    chk("tp2b_data",  o_data, 32'd7);
    chk("tp2b_flags", 32'(o_flags), 32'h0);

    // Illegal codes and counter saturation.
    p_fcn[1] = 5'd9; p_a[1] = $urandom; p_b[1] = $urandom;
    one_txn(1'b0, 1'b1, 0, 1'b0, 1'b0, "tp3");
    chk("tp3_data",  o_data, 32'd0);
    chk("tp3_flags", 32'(o_flags), 32'h8);
    chk("tp3_cnt",   32'(bus.err_cnt), 32'd1);
    for (int i = 0; i < 299; i++) begin
      p_fcn[1] = 5'($urandom_range(6, 31));
      p_a[1]   = $urandom;
      p_b[1]   = $urandom;
      one_txn(1'b0, 1'b1, 0, 1'b0, 1'b0, "ill");
    end
    chk("tp3_sat", 32'(bus.err_cnt), 32'hFF);

    // Response stall with the other port waiting.
    do_reset("rst2");
    rnd_req(0, 1'b0);
    rnd_req(1, 1'b0);
    one_txn(1'b1, 1'b1, 10, 1'b0, 1'b0, "tp4a");
    one_txn(1'b0, 1'b1, 0, 1'b0, 1'b0, "tp4b");

    // Reset while a transaction is in EXEC.
    do_reset("rst3");
    p_fcn[0] = 5'd7; p_a[0] = $urandom; p_b[0] = $urandom;
    drv_v0 = 1'b1;
    @(posedge clk);
    #1;
    chk("tp5_exec_fcn", 32'(bus.alu_fcn), 32'd7);
    drv_v0 = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_outputs("tp5");
    @(posedge clk);
    #1;
    rst = 1'b0;
    fav = 0;
    err_model = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("tp5_no_rsp", 32'(bus.rsp_valid), 32'd0);
      chk("tp5_cnt",    32'(bus.err_cnt), 32'd0);
    end

    // Both ports continuously valid: strict alternation.
    do_reset("rst4");
    rnd_req(0, 1'b0);
    rnd_req(1, 1'b0);
    grant_log.delete();
    for (int i = 0; i < 6; i++) one_txn(1'b1, 1'b1, 0, 1'b1, 1'b0, "tp6");
    for (int i = 0; i < 6; i++) chk("tp6_grant_order", 32'(grant_log[i]), 32'(i % 2));

    // Random traffic, stalls and occasional illegal codes.
    do_reset("rst5");
    rnd_req(0, 1'b1);
    rnd_req(1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      int vsel;
      vsel = int'($urandom_range(1, 3));
      one_txn(vsel[0], vsel[1], int'($urandom_range(0, 3)), 1'b1, 1'b1, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
